// File: rtl/wb_write_queue.sv
// Writeback queue: merges LSU (port 0) and ALU (port 1) results into an in-order FIFO
// that drains one entry per cycle into the register-file write port, with bypass queries.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_valid,
  output logic                       s0_ready,
  input  logic [AW-1:0]              s0_idx,
  input  logic [DW-1:0]              s0_data,
  input  logic                       s1_valid,
  output logic                       s1_ready,
  input  logic [AW-1:0]              s1_idx,
  input  logic [DW-1:0]              s1_data,
  output logic                       write_en,
  output logic [AW-1:0]              wa,
  output logic [DW-1:0]              wd,
  input  logic [AW-1:0]              q1_idx,
  output logic                       q1_hit,
  output logic [DW-1:0]              q1_data,
  input  logic [AW-1:0]              q2_idx,
  output logic                       q2_hit,
  output logic [DW-1:0]              q2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] LEFT1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LEFT2 = CW'(DEPTH - 2);

  logic [AW-1:0] mem_idx  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic push0;
  logic push1;
  logic pop;
  logic [PW-1:0] wr_ptr1;

  // Ready looks only at registered occupancy; the concurrent pop is not credited.
  assign s0_ready = (count < FULL);
  assign s1_ready = (count <= LEFT2) | ((count == LEFT1) & ~s0_valid);

  // x0 results complete the handshake but are never stored.
  assign push0   = s0_valid & s0_ready & (s0_idx != '0);
  assign push1   = s1_valid & s1_ready & (s1_idx != '0);
  assign pop     = (count != '0);
  assign wr_ptr1 = wr_ptr + PW'(push0);

  assign write_en = pop;
  assign wa       = pop ? mem_idx[rd_ptr]  : '0;
  assign wd       = pop ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Entry storage is qualified by occupancy only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0) begin
        mem_idx[wr_ptr]  <= s0_idx;
        mem_data[wr_ptr] <= s0_data;
      end
      if (push1) begin
        mem_idx[wr_ptr1]  <= s1_idx;
        mem_data[wr_ptr1] <= s1_data;
      end
    end
  end

  // Walk from head to tail so the youngest matching entry wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot    = '0;
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((q1_idx != '0) && (mem_idx[slot] == q1_idx)) begin
          q1_hit  = 1'b1;
          q1_data = mem_data[slot];
        end
        if ((q2_idx != '0) && (mem_idx[slot] == q2_idx)) begin
          q2_hit  = 1'b1;
          q2_data = mem_data[slot];
        end
      end
    end
  end

endmodule
